// File: rtl/img2col_patch_gen_if.sv
// Stream bundle for the img2col patch generator:
// raster pixels in, flattened K x K patches out, frame control.
interface img2col_patch_gen_if #(
    parameter int DATA_W = 8,
    parameter int K      = 3
);
    logic                  start;
    logic                  map_finish;
    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [K*K*DATA_W-1:0] out_data;
    logic                  out_ready;
    logic                  map_done;

    modport master (
        output start, map_finish, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, map_done
    );

    modport slave (
        input  start, map_finish, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, map_done
    );
endinterface

// File: rtl/img2col_patch_gen.sv
// Sliding-window img2col: K-1 line buffers feed a K x K window
// that emits one stride-1, unpadded patch per interior pixel.
module img2col_patch_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int K      = 3
) (
    input  logic               clk,
    input  logic               nrst,
    img2col_patch_gen_if.slave bus
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int OW = K * K * DATA_W;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              out_valid;
    logic              map_done;
    logic              in_ready;
    logic              restart;
    logic              leave_drain;
    logic              accept;
    logic              last_px;
    logic              hit;
    logic [OW-1:0]     out_flat;
    logic [DATA_W-1:0] win [K][K];
    logic [DATA_W-1:0] lb  [K-1][IMG_W];

    assign last_px = (row == ROW_LAST) && (col == COL_LAST);
    assign hit     = (row >= ROW_FIRST) && (col >= COL_FIRST);
    assign accept  = bus.in_valid && in_ready && !bus.map_finish;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        restart     = 1'b0;
        leave_drain = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = ACTIVE;
                    restart    = 1'b1;
                end
            end
            ACTIVE: begin
                in_ready = !out_valid || bus.out_ready;
                if (bus.in_valid && in_ready && last_px)
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (!out_valid || bus.out_ready) begin
                    state_next  = IDLE;
                    leave_drain = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // abort wins over start, acceptance and completion
        if (bus.map_finish) begin
            state_next  = IDLE;
            restart     = 1'b0;
            leave_drain = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            row       <= '0;
            col       <= '0;
            out_valid <= 1'b0;
            map_done  <= 1'b0;
        end else begin
            map_done <= leave_drain;
            if (restart || bus.map_finish) begin
                row       <= '0;
                col       <= '0;
                out_valid <= 1'b0;
            end else begin
                if (accept) begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                if (accept && hit)     out_valid <= 1'b1;
                else if (bus.out_ready) out_valid <= 1'b0;
            end
        end
    end

    // window only moves on acceptance, so a pending patch stays put
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    win[i][j] <= '0;
        end else if (restart) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    win[i][j] <= '0;
        end else if (accept) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K - 1; j++)
                    win[i][j] <= win[i][j+1];
            for (int i = 0; i < K - 1; i++)
                win[i][K-1] <= lb[K-2-i][col];
            win[K-1][K-1] <= bus.in_data;
        end
    end

    // lb[b] holds row (row-1-b) at the current column
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][col] <= bus.in_data;
            for (int b = 1; b < K - 1; b++)
                lb[b][col] <= lb[b-1][col];
        end
    end

    always_comb begin
        out_flat = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                out_flat[(i*K+j)*DATA_W +: DATA_W] = win[i][j];
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_flat;
    assign bus.map_done  = map_done;
endmodule
